fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the write port of the async fifo between NUM_REQ requesters.
//  Sits entirely in the write-clock domain, in front of the fifo write port.
//  Grants one requester at a time for a burst of up to BURST_LEN beats.
//  Drives the fifo write enable and data, and back-pressures requesters from the fifo full flag.
// PARAMETERS
//  DATASIZE   8  data width per beat, equal to the fifo DATASIZE
//  NUM_REQ    4  number of requesters, 2..8
//  IDX_W      2  width of the grant index, equal to clog2(NUM_REQ)
//  BURST_LEN  4  maximum beats per grant, 1..16
// PORTS
//  i_wr_clk_pad     in   1                  write clock; the block's only clock
//  i_wr_rst_n_pad   in   1                  asynchronous, active-low reset
//  i_req_valid      in   NUM_REQ            per-requester valid; bit k belongs to requester k
//  i_req_data       in   NUM_REQ*DATASIZE   requester k data at [k*DATASIZE +: DATASIZE]
//  o_req_ready      out  NUM_REQ            per-requester ready, one-hot or zero
//  i_fifo_full      in   1                  fifo full flag (o_full_pad)
//  o_fifo_wr_en     out  1                  fifo write enable (i_wr_en_pad)
//  o_fifo_wr_data   out  DATASIZE           fifo write data (i_wr_data_pad)
//  o_grant_id       out  IDX_W              index of the current or last granted requester
//  o_busy           out  1                  1 while in GRANT
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the caller) clears:
//    state=IDLE, o_busy=0, o_grant_id=0, o_req_ready=0, o_fifo_wr_en=0, o_fifo_wr_data=0.
//  - Reset sets the rr pointer last=NUM_REQ-1, so requester 0 wins first; beat_cnt=0.
//  - Two-state FSM with states IDLE and GRANT.
//  - IDLE:
//    - If any i_req_valid bit is set, pick the first set bit searching last+1, last+2, ... (mod NUM_REQ).
//    - Register that index in grant_id, clear beat_cnt and go to GRANT.
//    - Arbitration latency is 1 cycle; no transfer takes place in IDLE.
//  - GRANT, with g = grant_id:
//    - Combinational outputs:
//      - o_req_ready[g] = !i_fifo_full; all other ready bits are 0.
//      - o_fifo_wr_en = i_req_valid[g] & !i_fifo_full.
//      - o_fifo_wr_data = data slice g. Outside GRANT the data output is 0.
//  - Transfer: a beat completes on a clock edge where o_fifo_wr_en=1; the arbiter then increments beat_cnt.
//  - Exit GRANT to IDLE and set last=g in any of these cases:
//    - a transfer occurs with beat_cnt==BURST_LEN-1, or
//    - i_req_valid[g]==0 (the requester releases the grant).
//  - Full: while i_fifo_full=1 the arbiter stays in GRANT, beat_cnt holds and no write takes place. There is no timeout.
//  - Requester rule: once valid is asserted, data is held stable until ready is seen.
//  - Requester rule: a requester drops valid only after a completed beat.
//  - Simultaneous requests resolve strictly by round-robin order.
//  - A requester asserting valid during another requester's burst waits for that burst to end.
//  - A bubble of 1 IDLE cycle occurs between bursts, so peak throughput is BURST_LEN/(BURST_LEN+1).
//  - beat_cnt is IDX-independent with width clog2(BURST_LEN)+1. It never wraps, because exit happens at BURST_LEN-1.
//  - Reset mid-burst: returns immediately to IDLE and drops o_fifo_wr_en. The partially sent burst is not replayed.
//  - o_grant_id holds its last value in IDLE.
// CONFIGURATION
//  WR_ARB_HIPRI_EN
//  - Defined:
//    - Requester 0 is high priority: in IDLE, i_req_valid[0]=1 always wins over the rr search.
//    - A requester-0 grant does not update the pointer last.
//    - Bursts in progress are never pre-empted.
//  - Undefined: all requesters are equal, using pure round-robin.
// TESTING
//  1. Reset: hold i_wr_rst_n_pad=0 with valid=4'b1111 -> o_fifo_wr_en=0, o_req_ready=0, o_busy=0, o_grant_id=0.
//  2. Single requester: req2 sends 6 beats A0..A5, fifo never full.
//     -> Writes A0..A3 (grant 2), then 1 IDLE cycle, then A4,A5. The fifo read side returns A0..A5 in order.
//  3. Round-robin: valid=4'b1111 continuously, BURST_LEN=4.
//     -> Grant order 0,1,2,3,0; each burst is 4 beats, with 16 writes per 20 cycles.
//  4. Full stall: force i_fifo_full=1 for 5 cycles mid-burst after beat 2.
//     -> o_fifo_wr_en=0 and o_req_ready=0 during the stall; beat_cnt holds; beats 3,4 complete after release with no loss.
//  5. Early release: req1 drops valid after 2 beats.
//     -> Returns to IDLE; the next grant goes to requester 2 if it is valid.
//  6. Reset mid-burst: assert reset after beat 1.
//     -> o_fifo_wr_en drops asynchronously; after release req0 is granted first.
//     With WR_ARB_HIPRI_EN defined: req0 and req3 valid in IDLE -> grant 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async fifo write port between NUM_REQ requesters (write-clock domain).
// Optional feature macro WR_ARB_HIPRI_EN: requester 0 wins every arbitration it takes part in.
module fifo_wr_arbiter #(
  parameter int DATASIZE  = 8,
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                        i_wr_clk_pad,
  input  logic                        i_wr_rst_n_pad,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATASIZE-1:0] i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_wr_en,
  output logic [DATASIZE-1:0]         o_fifo_wr_data,
  output logic [IDX_W-1:0]            o_grant_id,
  output logic                        o_busy
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                           state, state_nxt;
  logic [IDX_W-1:0]                 grant_id, grant_nxt;
  logic [IDX_W-1:0]                 last, last_nxt;
  logic [CNT_W-1:0]                 beat_cnt, beat_nxt;
  logic [IDX_W-1:0]                 pick, idx;
  logic                             pick_vld;
  logic                             keep_last;
  logic                             g_valid, xfer;
  logic [NUM_REQ-1:0][DATASIZE-1:0] req_data;

  assign req_data = i_req_data;

  // Walk from the farthest candidate to the nearest so the nearest set bit after last wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDX_W'((int'(last) + i) % NUM_REQ);
      if (i_req_valid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
`ifdef WR_ARB_HIPRI_EN
    if (i_req_valid[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

`ifdef WR_ARB_HIPRI_EN
  assign keep_last = (grant_id == '0);
`else
  assign keep_last = 1'b0;
`endif

  assign o_busy         = (state == GRANT);
  assign g_valid        = i_req_valid[grant_id];
  assign xfer           = o_busy && g_valid && !i_fifo_full;
  assign o_fifo_wr_en   = xfer;
  assign o_fifo_wr_data = o_busy ? req_data[grant_id] : '0;
  assign o_grant_id     = grant_id;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_ready
    assign o_req_ready[k] = o_busy && !i_fifo_full && (grant_id == IDX_W'(k));
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          grant_nxt = pick;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        // Release by the requester or the last beat of the burst both hand the port back.
        if (!g_valid || (xfer && beat_cnt == CNT_W'(BURST_LEN - 1))) begin
          state_nxt = IDLE;
          if (!keep_last) last_nxt = grant_id;
        end else if (xfer) begin
          beat_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_wr_clk_pad or negedge i_wr_rst_n_pad) begin
    if (!i_wr_rst_n_pad) begin
      state    <= IDLE;
      grant_id <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule
